// File: rtl/bennett_pkg.sv
// ---------------------------------------------------------------------------
// bennett_pkg
// Shared types and defaults for the Bennett adiabatic phase-clock generator.
//   bennett_state_t    : FSM states IDLE / RISE / HOLD / FALL
//   BENNETT_*_DEF      : default WIDTH / STEP / HOLD parameter values
//   bennett_cnt_bits() : counter width able to hold 0..max_val inclusive
// ---------------------------------------------------------------------------
package bennett_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HOLD = 2'd2,
    FALL = 2'd3
  } bennett_state_t;

  localparam int unsigned BENNETT_WIDTH_DEF = 13;
  localparam int unsigned BENNETT_STEP_DEF  = 1;
  localparam int unsigned BENNETT_HOLD_DEF  = 1;

  // Bits needed to count up to max_val (inclusive); always at least 1.
  function automatic int unsigned bennett_cnt_bits(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : bennett_pkg

// File: rtl/bennett_step_timer.sv
// ---------------------------------------------------------------------------
// bennett_step_timer
// Phase-edge cadence generator. While i_run is high it emits a one-cycle
// o_tick every STEP clk cycles, measured from the last clear.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   i_run   : count enable (high while the phase ladder is moving)
//   i_clear : restart the STEP interval (asserted on every phase edge)
//   o_tick  : combinational one-cycle pulse on the STEP-th cycle
// ---------------------------------------------------------------------------
module bennett_step_timer
  import bennett_pkg::*;
#(
  parameter int unsigned STEP = BENNETT_STEP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CW = bennett_cnt_bits(STEP);
  localparam logic [CW-1:0] LAST = CW'(STEP - 1);

  logic [CW-1:0] r_cnt;

  // Tick is taken from the current count so the phase edge lands exactly
  // STEP cycles after the previous one.
  assign o_tick = i_run && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule : bennett_step_timer

// File: rtl/bennett_clock_gen.sv
// ---------------------------------------------------------------------------
// bennett_clock_gen
// Bennett-style adiabatic phase-clock generator. A thermometer-coded bank of
// WIDTH phase clocks rises LSB->MSB one bit every STEP cycles, holds all-high
// for HOLD cycles, then falls MSB->LSB one bit every STEP cycles.
//
// Parameters:
//   WIDTH : number of phase clocks (>= 1)
//   STEP  : clk cycles between successive phase edges (>= 1)
//   HOLD  : clk cycles spent all-high (>= 1)
// Ports:
//   clk      : system clock, all state on rising edge
//   reset    : asynchronous active-low reset
//   en       : start a new Bennett cycle from IDLE
//   stall    : freeze the hold countdown while in HOLD
//   clkp     : positive phase clocks (thermometer coded)
//   clkn     : negative phase clocks, always ~clkp
//   fclk_pos : high exactly while in HOLD (all clkp bits high)
//   instFlag : one-cycle pulse after each completed Bennett cycle
//   busy     : high in every state except IDLE
// Configuration macro:
//   BENNETT_STALL_EN : when defined, stall freezes the hold countdown;
//                      otherwise stall is ignored and HOLD is fixed length.
// ---------------------------------------------------------------------------
module bennett_clock_gen
  import bennett_pkg::*;
#(
  parameter int unsigned WIDTH = BENNETT_WIDTH_DEF,
  parameter int unsigned STEP  = BENNETT_STEP_DEF,
  parameter int unsigned HOLD  = BENNETT_HOLD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             stall,
  output logic [WIDTH-1:0] clkp,
  output logic [WIDTH-1:0] clkn,
  output logic             fclk_pos,
  output logic             instFlag,
  output logic             busy
);

  localparam int unsigned HW = bennett_cnt_bits(HOLD);
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD);
  localparam logic [WIDTH-1:0] PHASE_LSB = WIDTH'(1);

  // The HOLD parameter shadows the imported enum literal of the same name,
  // so state literals are package-qualified throughout.
  bennett_state_t   r_state, w_state_nxt;
  logic [WIDTH-1:0] r_clkp,  w_clkp_nxt;
  logic [HW-1:0]    r_hold_cnt, w_hold_nxt;
  logic             r_inst,  w_inst_nxt;

  logic w_stall;
  logic w_tick;
  logic w_run;
  logic w_phase_edge;

`ifdef BENNETT_STALL_EN
  assign w_stall = stall;
`else
  logic w_unused_stall;
  assign w_unused_stall = stall;
  assign w_stall        = 1'b0;
`endif

  assign w_run        = (r_state == bennett_pkg::RISE) || (r_state == bennett_pkg::FALL);
  assign w_phase_edge = (w_clkp_nxt != r_clkp);

  bennett_step_timer #(
    .STEP (STEP)
  ) u_step_timer (
    .clk     (clk),
    .rst_n   (reset),
    .i_run   (w_run),
    .i_clear (w_phase_edge),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= bennett_pkg::IDLE;
      r_clkp     <= '0;
      r_hold_cnt <= '0;
      r_inst     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clkp     <= w_clkp_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_inst     <= w_inst_nxt;
    end
  end

  // Rising shifts a 1 in at the bottom and falling shifts the top bit out,
  // which keeps clkp thermometer coded and changes one bit per edge.
  always_comb begin
    w_state_nxt = r_state;
    w_clkp_nxt  = r_clkp;
    w_hold_nxt  = r_hold_cnt;
    w_inst_nxt  = 1'b0;

    unique case (r_state)
      bennett_pkg::IDLE: begin
        if (en) begin
          w_clkp_nxt = PHASE_LSB;
          // With a single phase the first edge already raises the top bit.
          if (WIDTH == 1) begin
            w_state_nxt = bennett_pkg::HOLD;
            w_hold_nxt  = HOLD_LOAD;
          end else begin
            w_state_nxt = bennett_pkg::RISE;
          end
        end
      end

      bennett_pkg::RISE: begin
        if (w_tick) begin
          w_clkp_nxt = (r_clkp << 1) | PHASE_LSB;
          if (w_clkp_nxt[WIDTH-1]) begin
            w_state_nxt = bennett_pkg::HOLD;
            w_hold_nxt  = HOLD_LOAD;
          end
        end
      end

      bennett_pkg::HOLD: begin
        if (!w_stall) begin
          if (r_hold_cnt <= HW'(1)) begin
            w_clkp_nxt = r_clkp >> 1;
            w_hold_nxt = '0;
            // A single phase falls straight back to IDLE on this edge.
            if (WIDTH == 1) begin
              w_state_nxt = bennett_pkg::IDLE;
              w_inst_nxt  = 1'b1;
            end else begin
              w_state_nxt = bennett_pkg::FALL;
            end
          end else begin
            w_hold_nxt = r_hold_cnt - HW'(1);
          end
        end
      end

      bennett_pkg::FALL: begin
        if (w_tick) begin
          w_clkp_nxt = r_clkp >> 1;
          if (w_clkp_nxt == '0) begin
            w_state_nxt = bennett_pkg::IDLE;
            w_inst_nxt  = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = bennett_pkg::IDLE;
        w_clkp_nxt  = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  assign clkp     = r_clkp;
  assign clkn     = ~r_clkp;
  assign fclk_pos = (r_state == bennett_pkg::HOLD);
  assign busy     = (r_state != bennett_pkg::IDLE);
  assign instFlag = r_inst;

endmodule : bennett_clock_gen

// File: tb/tb_bennett_clock_gen.sv
// ---------------------------------------------------------------------------
// tb_bennett_clock_gen
// Three generator instances (13/1/1, 4/2/3, 1/1/2 for WIDTH/STEP/HOLD) share
// clk/reset/en/stall. Directed scenarios use constant expectations; the
// random scenario compares against a position-in-cycle model.
// ---------------------------------------------------------------------------
module tb_bennett_clock_gen;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b0;
  logic stall = 1'b0;

  logic [12:0] c13, n13;
  logic [3:0]  c4,  n4;
  logic [0:0]  c1,  n1;
  logic        fp13, fp4, fp1, in13, in4, in1, b13, b4, b1;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  bennett_clock_gen #(.WIDTH(13), .STEP(1), .HOLD(1)) u_dut13 (
    .clk(clk), .reset(reset), .en(en), .stall(stall),
    .clkp(c13), .clkn(n13), .fclk_pos(fp13), .instFlag(in13), .busy(b13));

  bennett_clock_gen #(.WIDTH(4), .STEP(2), .HOLD(3)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .stall(stall),
    .clkp(c4), .clkn(n4), .fclk_pos(fp4), .instFlag(in4), .busy(b4));

  bennett_clock_gen #(.WIDTH(1), .STEP(1), .HOLD(2)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .stall(stall),
    .clkp(c1), .clkn(n1), .fclk_pos(fp1), .instFlag(in1), .busy(b1));

  logic [12:0] act_clkp [3];
  logic [12:0] act_clkn [3];
  logic        act_fp   [3];
  logic        act_inst [3];
  logic        act_busy [3];

  always_comb begin
    act_clkp[0] = c13;             act_clkn[0] = n13;
    act_clkp[1] = {9'd0, c4};      act_clkn[1] = {9'd0, n4};
    act_clkp[2] = {12'd0, c1};     act_clkn[2] = {12'd0, n1};
    act_fp[0]   = fp13; act_fp[1]   = fp4; act_fp[2]   = fp1;
    act_inst[0] = in13; act_inst[1] = in4; act_inst[2] = in1;
    act_busy[0] = b13;  act_busy[1] = b4;  act_busy[2] = b1;
  end

  // ---------------- reference model ----------------
  // Each instance is tracked only by its position j within the Bennett
  // period: j=0 idle, then (W-1)*S rising cycles, H hold cycles, (W-1)*S
  // falling cycles. The number of high phases follows from j alone.
  int mw [3] = '{13, 4, 1};
  int ms [3] = '{1, 2, 1};
  int mh [3] = '{1, 3, 2};
  int mj [3];
  bit minst [3];

  function automatic int period_of(input int i);
    return 2 * (mw[i] - 1) * ms[i] + mh[i] + 1;
  endfunction

  function automatic bit in_hold(input int i);
    int r;
    r = (mw[i] - 1) * ms[i];
    return (mj[i] > r) && (mj[i] <= r + mh[i]);
  endfunction

  function automatic int level_of(input int i);
    int r;
    r = (mw[i] - 1) * ms[i];
    if (mj[i] == 0)              return 0;
    if (mj[i] <= r)              return 1 + (mj[i] - 1) / ms[i];
    if (mj[i] <= r + mh[i])      return mw[i];
    return mw[i] - 1 - (mj[i] - r - mh[i] - 1) / ms[i];
  endfunction

  function automatic logic [12:0] thermo(input int lvl);
    logic [31:0] t;
    t = (32'd1 << lvl) - 32'd1;
    return t[12:0];
  endfunction

  function automatic logic [12:0] width_mask(input int i);
    return thermo(mw[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mj[i] = 0;
      minst[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit en_s, input bit stall_s);
    bit stall_eff;
`ifdef BENNETT_STALL_EN
    stall_eff = stall_s;
`else
    stall_eff = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      minst[i] = 1'b0;
      if (mj[i] == 0) begin
        if (en_s) mj[i] = 1;
      end else if (!(stall_eff && in_hold(i))) begin
        mj[i] = mj[i] + 1;
        if (mj[i] == period_of(i)) begin
          mj[i] = 0;
          minst[i] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- per-edge invariants ----------------
  logic [12:0] prev_clkp [3];
  bit          prev_rst_hi = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        assert (act_clkn[i] === (~act_clkp[i] & width_mask(i)))
          else $error("FAIL inv_clkn[%0d] got=%h exp=%h", i, act_clkn[i], ~act_clkp[i] & width_mask(i));
        assert ((act_clkp[i] & (act_clkp[i] + 13'd1)) == 13'd0)
          else $error("FAIL inv_thermo[%0d] got=%h exp=thermometer", i, act_clkp[i]);
        if (prev_rst_hi && reset)
          assert ($countones(act_clkp[i] ^ prev_clkp[i]) <= 1)
            else $error("FAIL inv_toggle[%0d] got=%h->%h exp=<=1 bit change", i, prev_clkp[i], act_clkp[i]);
        prev_clkp[i] = act_clkp[i];
      end
    end
    prev_rst_hi = reset && mon_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic apply_reset();
    en = 1'b0;
    stall = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    en = 1'b0;
    stall = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (act_clkp[i] !== 13'd0) begin failures++; $display("FAIL reset_clkp[%0d] got=%h exp=0", i, act_clkp[i]); end
      checks++; if (act_clkn[i] !== width_mask(i)) begin failures++; $display("FAIL reset_clkn[%0d] got=%h exp=%h", i, act_clkn[i], width_mask(i)); end
      checks++; if (act_fp[i] !== 1'b0) begin failures++; $display("FAIL reset_fclk[%0d] got=%b exp=0", i, act_fp[i]); end
      checks++; if (act_inst[i] !== 1'b0) begin failures++; $display("FAIL reset_inst[%0d] got=%b exp=0", i, act_inst[i]); end
      checks++; if (act_busy[i] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, act_busy[i]); end
    end
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b1;
    // en low after release: must stay idle
    repeat (3) begin @(posedge clk); #2; end
    checks++; if (b13 !== 1'b0 || c13 !== 13'd0) begin failures++; $display("FAIL idle_en0 got=busy%b/%h exp=busy0/0000", b13, c13); end
  endtask

  task automatic test_period();
    int last [3];
    int npulse [3];
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin last[i] = 0; npulse[i] = 0; end
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #2;
      if (c == 13) begin
        checks++; if (c13 !== 13'h1FFF) begin failures++; $display("FAIL rise13_full got=%h exp=1fff", c13); end
      end
      for (int i = 0; i < 3; i++) begin
        if (act_inst[i] === 1'b1) begin
          npulse[i]++;
          checks++;
          if (c - last[i] != period_of(i)) begin
            failures++; $display("FAIL period[%0d] got=%0d exp=%0d", i, c - last[i], period_of(i));
          end
          last[i] = c;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (npulse[i] != 70 / period_of(i)) begin
        failures++; $display("FAIL pulse_count[%0d] got=%0d exp=%0d", i, npulse[i], 70 / period_of(i));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_seq4();
    logic [3:0] seq [16] = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF,
                             4'hF, 4'h7, 4'h7, 4'h3, 4'h3, 4'h1, 4'h1, 4'h0};
    logic       fpt [16] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #2;
      checks++; if (c4 !== seq[k]) begin failures++; $display("FAIL seq4_clkp k=%0d got=%h exp=%h", k, c4, seq[k]); end
      checks++; if (fp4 !== fpt[k]) begin failures++; $display("FAIL seq4_fclk k=%0d got=%b exp=%b", k, fp4, fpt[k]); end
      checks++; if (in4 !== (k == 15)) begin failures++; $display("FAIL seq4_inst k=%0d got=%b exp=%b", k, in4, (k == 15)); end
    end
    en = 1'b0;
  endtask

  task automatic test_stall();
    bit found;
    int hi_cnt;
    int exp_hi;
`ifdef BENNETT_STALL_EN
    exp_hi = 3 + 5;
`else
    exp_hi = 3;
`endif
    apply_reset();
    en = 1'b1;
    @(posedge clk); #2;
    en = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (fp4 === 1'b1) found = 1'b1;
      else begin @(posedge clk); #2; end
    end
    checks++; if (!found) begin failures++; $display("FAIL stall_reach_hold got=timeout exp=fclk_pos"); end
    hi_cnt = found ? 1 : 0;
    stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #2;
      if (fp4 === 1'b1) hi_cnt++;
    end
    stall = 1'b0;
    for (int s = 0; s < 20; s++) begin
      @(posedge clk); #2;
      if (fp4 === 1'b1) hi_cnt++;
    end
    checks++; if (hi_cnt != exp_hi) begin failures++; $display("FAIL stall_hold_len got=%0d exp=%0d", hi_cnt, exp_hi); end
  endtask

  task automatic test_en_pulse();
    int npulse [3];
    apply_reset();
    en = 1'b1;
    @(posedge clk); #2;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      npulse[i] = 0;
      checks++; if (act_busy[i] !== 1'b1) begin failures++; $display("FAIL pulse_busy_start[%0d] got=%b exp=1", i, act_busy[i]); end
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) if (act_inst[i] === 1'b1) npulse[i]++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (npulse[i] != 1) begin failures++; $display("FAIL pulse_once[%0d] got=%0d exp=1", i, npulse[i]); end
      checks++; if (act_busy[i] !== 1'b0) begin failures++; $display("FAIL pulse_busy_end[%0d] got=%b exp=0", i, act_busy[i]); end
      checks++; if (act_clkp[i] !== 13'd0) begin failures++; $display("FAIL pulse_clkp_end[%0d] got=%h exp=0", i, act_clkp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    en = 1'b1;
    repeat (7) begin @(posedge clk); #2; end
    checks++; if (c13 !== 13'h007F) begin failures++; $display("FAIL mid_pre got=%h exp=007f", c13); end
    reset = 1'b0;
    #1;
    checks++; if (c13 !== 13'd0) begin failures++; $display("FAIL mid_clkp got=%h exp=0000", c13); end
    checks++; if (n13 !== 13'h1FFF) begin failures++; $display("FAIL mid_clkn got=%h exp=1fff", n13); end
    checks++; if (b13 !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", b13); end
    @(posedge clk); #2;
    checks++; if (c13 !== 13'd0) begin failures++; $display("FAIL mid_held got=%h exp=0000", c13); end
    reset = 1'b1;
    @(posedge clk); #2;
    checks++; if (c13 !== 13'h0001) begin failures++; $display("FAIL mid_restart got=%h exp=0001", c13); end
    en = 1'b0;
  endtask

  task automatic test_random();
    logic [12:0] ec;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      en    = ($urandom_range(0, 2) != 0);
      stall = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
      end
      @(posedge clk);
      if (reset) model_step(en, stall);
      #2;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
        ec = thermo(level_of(i));
        checks++; if (act_clkp[i] !== ec) begin failures++; $display("FAIL rand_clkp[%0d] n=%0d got=%h exp=%h", i, n, act_clkp[i], ec); end
        checks++; if (act_clkn[i] !== (~ec & width_mask(i))) begin failures++; $display("FAIL rand_clkn[%0d] n=%0d got=%h exp=%h", i, n, act_clkn[i], ~ec & width_mask(i)); end
        checks++; if (act_fp[i] !== in_hold(i)) begin failures++; $display("FAIL rand_fclk[%0d] n=%0d got=%b exp=%b", i, n, act_fp[i], in_hold(i)); end
        checks++; if (act_inst[i] !== minst[i]) begin failures++; $display("FAIL rand_inst[%0d] n=%0d got=%b exp=%b", i, n, act_inst[i], minst[i]); end
        checks++; if (act_busy[i] !== (mj[i] != 0)) begin failures++; $display("FAIL rand_busy[%0d] n=%0d got=%b exp=%b", i, n, act_busy[i], (mj[i] != 0)); end
      end
    end
    en = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_period();
    test_seq4();
    test_stall();
    test_en_pulse();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bennett_clock_gen

// File: doc/bennett_clock_gen.md
BENNETT_CLOCK_GEN -- requirements
Module: bennett_clock_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 13, giving the number of adiabatic phase clocks.
REQ-002 The block SHALL have parameter STEP, default 1, giving the clk cycles between successive phase edges; legal range is 1 or more.
REQ-003 The block SHALL have parameter HOLD, default 1, giving the clk cycles spent all-high; legal range is 1 or more.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single system clock, with all state on its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-006 Port en SHALL be an input, 1 bit wide: while 1, the block starts a new Bennett cycle from IDLE.
REQ-007 Port stall SHALL be an input, 1 bit wide: while 1 in HOLD, it freezes the hold countdown.
REQ-008 Port clkp SHALL be an output, WIDTH bits wide: positive phase clocks.
REQ-009 Port clkn SHALL be an output, WIDTH bits wide: negative phase clocks, always bitwise ~clkp.
REQ-010 Port fclk_pos SHALL be an output, 1 bit wide: 1 exactly while in HOLD, when all clkp bits are 1.
REQ-011 Port instFlag SHALL be an output, 1 bit wide: a one-cycle pulse marking completion of each Bennett cycle.
REQ-012 Port busy SHALL be an output, 1 bit wide: 1 in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, RISE, HOLD and FALL.
REQ-014 IDLE: on an edge where en=1, the FSM SHALL set clkp[0] and go to RISE; when en=0 it stays in IDLE with clkp all-zero.
REQ-015 RISE: every STEP cycles, the FSM SHALL set the next-higher clkp bit, filling from LSB to MSB.
REQ-016 RISE: on the edge that sets clkp[WIDTH-1], the FSM SHALL go to HOLD and load the hold counter with HOLD.
REQ-017 HOLD: the hold counter SHALL decrement each cycle with stall=0 and stay unchanged with stall=1.
REQ-018 HOLD: on the edge where the hold count expires, the FSM SHALL clear clkp[WIDTH-1] and go to FALL.
REQ-019 FALL: every STEP cycles, the FSM SHALL clear the next-lower bit, in reverse order of RISE (last raised, first lowered).
REQ-020 FALL: on the edge that clears clkp[0], the FSM SHALL go to IDLE and register instFlag=1 for exactly one cycle.
REQ-021 With en held at 1, the period SHALL be 2*(WIDTH-1)*STEP+HOLD+1 cycles, with one IDLE cycle per period.
REQ-022 en=0 during RISE, HOLD or FALL SHALL NOT abort the cycle: the cycle always unwinds to all-zero, then stays in IDLE.
REQ-023 clkp SHALL always be thermometer-coded, with the set bits contiguous from bit 0.
REQ-024 At most one clkp bit SHALL change per edge.
REQ-025 The step counter SHALL be $clog2(STEP+1) bits wide and SHALL reset to 0 on every phase edge.
REQ-026 The hold counter SHALL be $clog2(HOLD+1) bits wide.
REQ-027 WIDTH=1 SHALL be legal: the FSM goes IDLE->HOLD->IDLE with RISE and FALL collapsed to a single edge each.

Reset
REQ-028 While reset=0, the block SHALL asynchronously force state=IDLE, clkp=0, clkn=all-ones, fclk_pos=0, instFlag=0, busy=0 and both counters to 0.
REQ-029 Reset asserted mid-cycle SHALL drop all phases at once, accepting the non-adiabatic discharge.
REQ-030 After reset release, the first RISE SHALL begin on the first edge with en=1.

Configuration
REQ-031 With BENNETT_STALL_EN defined, stall SHALL behave as in REQ-017.
REQ-032 Without BENNETT_STALL_EN, the stall port SHALL remain present but be ignored, so HOLD always lasts exactly HOLD cycles.

Structure
REQ-033 Shared package bennett_pkg SHALL hold the state enum bennett_state_t (IDLE, RISE, HOLD, FALL).
REQ-034 bennett_pkg SHALL hold the default constants BENNETT_WIDTH_DEF=13, BENNETT_STEP_DEF=1 and BENNETT_HOLD_DEF=1.
REQ-035 The STEP cadence SHALL be implemented in one sub-module, bennett_step_timer, which takes a clear and emits a one-cycle tick every STEP cycles.

Verification
REQ-036 WIDTH=13, STEP=1, HOLD=1, en=1 held: clkp SHALL reach 13'h1FFF after 13 edges, and instFlag SHALL pulse every 26 cycles.
REQ-037 WIDTH=4, STEP=2, HOLD=3, en=1: clkp SHALL step 0001, 0011, 0111, 1111 at 2-cycle spacing; fclk_pos SHALL be high for 3 cycles; clkp SHALL step down 0111, 0011, 0001, 0000; the period SHALL be 16 cycles.
REQ-038 With BENNETT_STALL_EN, stall=1 for 5 cycles in HOLD SHALL make fclk_pos high for HOLD+5 cycles; without the macro, the same stimulus SHALL leave fclk_pos high for HOLD cycles.
REQ-039 en pulsed high for 1 cycle: exactly one full cycle and one instFlag pulse SHALL occur, then busy=0 and clkp stays 0.
REQ-040 reset=0 asserted while clkp=13'h007F in RISE SHALL give clkp=0 and clkn=13'h1FFF immediately; a restart with en=1 SHALL produce clkp=13'h0001 on the next edge.
REQ-041 A bench assertion SHALL check on every edge that clkn==~clkp, that clkp is thermometer-coded, and that at most one bit toggles per edge.
